// File: rtl/mem_access.sv
// Multicycle load/store sequencer: checks size/alignment, builds the write bit-mask,
// and runs a req/ack bus cycle. Optional REQ timeout under `MEM_ACCESS_TIMEOUT_EN`.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] ir,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wrbits,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_access: TIMEOUT out of range 1..65535");
  end

  typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;
  state_t state, state_nxt;

  logic [2:0]  f3;
  logic        legal, misal, bad, accept, ack, tmo;
  logic [31:0] wrbits_nxt;

  assign f3     = ir[14:12];
  assign accept = (state == IDLE) && start;
  assign ack    = (state == REQ) && mem_ack;

  always_comb begin
    legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal = ((f3[1:0] == 2'b01) && addr[0]) ||
            ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    bad   = !legal || misal;
  end

  // Store data arrives pre-replicated, so the mask alone selects the lanes.
  always_comb begin
    wrbits_nxt = '0;
    if (we) begin
      case (f3[1:0])
        2'b00:   wrbits_nxt = 32'h0000_00FF << {addr[1:0], 3'b000};
        2'b01:   wrbits_nxt = 32'h0000_FFFF << {addr[1], 4'b0000};
        default: wrbits_nxt = '1;
      endcase
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [15:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (state != REQ)   cnt <= '0;
    else if (!mem_ack)       cnt <= cnt + 16'd1;
  end

  // Ack on the timeout edge takes priority.
  assign tmo = (state == REQ) && !mem_ack && (cnt == 16'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = bad ? FIN : REQ;
      REQ:     if (mem_ack || tmo) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == REQ);
    mem_req = (state == REQ);
    done    = (state == FIN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err        <= 1'b0;
      rdata      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wrbits <= '0;
      mem_wdata  <= '0;
    end else begin
      if (accept) err <= bad;
      else if (tmo) err <= 1'b1;
      if (accept && !bad) begin
        mem_we     <= we;
        mem_addr   <= {addr[31:2], 2'b00};
        mem_wrbits <= wrbits_nxt;
        mem_wdata  <= wdata;
      end
      if (ack && !mem_we) rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed vector bench for mem_access: table of single transactions plus
// hand-written sequences for ignored start, ack in IDLE, reset abort and timeout.
module tb_mem_access;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, we = 1'b0, mem_ack = 1'b0;
  logic [31:0] ir = '0, addr = '0, wdata = '0, mem_rdata = '0;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wrbits, mem_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_access #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .start(start), .we(we), .ir(ir), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wrbits(mem_wrbits), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rd;
    int          n;        // REQ cycles, ack raised in the last one
    logic        exp_err;
    logic [31:0] exp_wrbits;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("v%0d", i);
    @(negedge clock);
    we = v.we; ir = {17'b0, v.f3, 12'b0}; addr = v.addr; wdata = v.wdata; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (v.exp_err) begin
      chk({p, ".done"}, 32'(done), 32'd1);
      chk({p, ".err"}, 32'(err), 32'd1);
      chk({p, ".req"}, 32'(mem_req), 32'd0);
      chk({p, ".busy"}, 32'(busy), 32'd0);
      chk({p, ".rdata"}, rdata, v.exp_rdata);
      @(negedge clock);
      chk({p, ".done_off"}, 32'(done), 32'd0);
      chk({p, ".req_off"}, 32'(mem_req), 32'd0);
    end else begin
      for (int k = 1; k <= v.n; k++) begin
        chk({p, ".req"}, 32'(mem_req), 32'd1);
        chk({p, ".busy"}, 32'(busy), 32'd1);
        chk({p, ".done0"}, 32'(done), 32'd0);
        chk({p, ".addr"}, mem_addr, {v.addr[31:2], 2'b00});
        chk({p, ".wrbits"}, mem_wrbits, v.exp_wrbits);
        chk({p, ".we"}, 32'(mem_we), 32'(v.we));
        chk({p, ".wdata"}, mem_wdata, v.wdata);
        if (k == v.n) begin
          mem_ack = 1'b1;
          mem_rdata = v.bus_rd;
        end
        @(negedge clock);
      end
      mem_ack = 1'b0;
      chk({p, ".done"}, 32'(done), 32'd1);
      chk({p, ".busy_off"}, 32'(busy), 32'd0);
      chk({p, ".req_off"}, 32'(mem_req), 32'd0);
      chk({p, ".err"}, 32'(err), 32'd0);
      chk({p, ".rdata"}, rdata, v.exp_rdata);
      @(negedge clock);
      chk({p, ".done_off"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int ndone, nreq;
    //           we  f3      addr          wdata         bus_rd        n  err  wrbits        rdata
    vecs[0]  = '{1'b1, 3'b000, 32'h0000_1003, 32'hABAB_ABAB, 32'h1111_1111, 3, 1'b0, 32'hFF00_0000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 3'b010, 32'h0000_2000, 32'h0000_0000, 32'hDEAD_BEEF, 1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 3'b001, 32'h0000_0001, 32'h1234_1234, 32'h0,         1, 1'b1, 32'h0,         32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 3'b011, 32'h0000_3000, 32'h0,         32'h0,         1, 1'b1, 32'h0,         32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 3'b001, 32'h0000_0006, 32'h5A5A_5A5A, 32'h2222_2222, 2, 1'b0, 32'hFFFF_0000, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 3'b000, 32'h0000_0001, 32'h7777_7777, 32'h3333_3333, 1, 1'b0, 32'h0000_FF00, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 3'b100, 32'h0000_4003, 32'h0,         32'h1234_5678, 2, 1'b0, 32'h0,         32'h1234_5678};
    vecs[7]  = '{1'b0, 3'b101, 32'h0000_4003, 32'h0,         32'h0,         1, 1'b1, 32'h0,         32'h1234_5678};
    vecs[8]  = '{1'b1, 3'b010, 32'h0000_5002, 32'h0,         32'h0,         1, 1'b1, 32'h0,         32'h1234_5678};
    vecs[9]  = '{1'b0, 3'b110, 32'h0000_5000, 32'h0,         32'h0,         1, 1'b1, 32'h0,         32'h1234_5678};
    vecs[10] = '{1'b1, 3'b010, 32'h0000_5004, 32'hC0DE_C0DE, 32'h4444_4444, 1, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[11] = '{1'b0, 3'b001, 32'h0000_6002, 32'h0,         32'hCAFE_F00D, 1, 1'b0, 32'h0,         32'hCAFE_F00D};

    // Reset state
    @(negedge clock);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.we", 32'(mem_we), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.wrbits", mem_wrbits, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Second start during REQ must be ignored
    @(negedge clock);
    we = 1'b1; ir = {17'b0, 3'b010, 12'b0}; addr = 32'h0000_7000; wdata = 32'h5555_5555; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    we = 1'b0; addr = 32'h0000_8000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("ign.addr", mem_addr, 32'h0000_7000);
    chk("ign.we", 32'(mem_we), 32'd1);
    chk("ign.req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    ndone = 0; nreq = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (done) ndone++;
      if (mem_req) nreq++;
    end
    chk("ign.ndone", 32'(ndone), 32'd1);
    chk("ign.nreq", 32'(nreq), 32'd0);
    chk("ign.rdata", rdata, 32'hCAFE_F00D);

    // Ack while IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clock);
    @(negedge clock);
    mem_ack = 1'b0;
    chk("idle_ack.busy", 32'(busy), 32'd0);
    chk("idle_ack.done", 32'(done), 32'd0);
    chk("idle_ack.rdata", rdata, 32'hCAFE_F00D);

    // Reset mid-REQ drops req asynchronously and nothing is reissued
    @(negedge clock);
    we = 1'b0; ir = {17'b0, 3'b010, 12'b0}; addr = 32'h0000_9000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("rab.req_pre", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rab.req", 32'(mem_req), 32'd0);
    chk("rab.busy", 32'(busy), 32'd0);
    chk("rab.rdata", rdata, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    nreq = 0; ndone = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (mem_req) nreq++;
      if (done) ndone++;
    end
    chk("rab.nreq", 32'(nreq), 32'd0);
    chk("rab.ndone", 32'(ndone), 32'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // No ack: req held TIMEOUT cycles, then done with err
    @(negedge clock);
    we = 1'b0; ir = {17'b0, 3'b010, 12'b0}; addr = 32'h0000_A000; mem_rdata = 32'h7E7E_7E7E; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    nreq = 0; ndone = 0;
    for (int c = 0; c < 12 && ndone == 0; c++) begin
      if (mem_req) nreq++;
      if (done) begin
        ndone++;
        chk("tmo.err", 32'(err), 32'd1);
        chk("tmo.rdata", rdata, 32'd0);
        chk("tmo.req", 32'(mem_req), 32'd0);
      end
      if (ndone == 0) @(negedge clock);
    end
    chk("tmo.nreq", 32'(nreq), 32'd4);
    chk("tmo.ndone", 32'(ndone), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
